// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-logic datapath.
// Cells are {row[2:0], col[2:0]}, so a cell value is also its LED bit index.
package snake_pkg;

    typedef logic [5:0] cell_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_COMMIT,
        S_FOOD_REQ,
        S_FOOD_CHK,
        S_DONE
    } state_e;

    localparam cell_t INIT_HEAD = 6'o33;
    localparam cell_t INIT_TAIL = 6'o32;
    localparam cell_t INIT_FOOD = 6'o36;

    localparam int LOGIC_DONE = 0;
    localparam int GAME_END   = 1;

    function automatic logic [2:0] cell_row(input cell_t c);
        return c[5:3];
    endfunction

    function automatic logic [2:0] cell_col(input cell_t c);
        return c[2:0];
    endfunction

    // One cell in direction d; 3-bit fields wrap around the board edges.
    function automatic cell_t step_cell(input cell_t c, input dir_e d);
        logic [2:0] r;
        logic [2:0] k;
        r = cell_row(c);
        k = cell_col(c);
        case (d)
            DIR_UP:    r = r + 3'd1;
            DIR_DOWN:  r = r - 3'd1;
            DIR_LEFT:  k = k - 3'd1;
            default:   k = k + 3'd1;
        endcase
        return {r, k};
    endfunction

endpackage

// File: rtl/snake_if.sv
// Controller/PRNG/display bundle between the game controller and snake_logic.
interface snake_if;
    import snake_pkg::*;

    logic        tick;
    logic        no_update;
    logic [1:0]  direction;
    logic        logic_done;
    logic        game_end;
    logic        rand_req;
    logic        rand_ack;
    cell_t       rand_val;
    logic [63:0] led_flat;

    modport master (
        output tick, no_update, direction, rand_ack, rand_val,
        input  logic_done, game_end, rand_req, led_flat
    );

    modport slave (
        input  tick, no_update, direction, rand_ack, rand_val,
        output logic_done, game_end, rand_req, led_flat
    );

endinterface

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cells, head at the write pointer, tail at the read pointer.
module snake_body_fifo
    import snake_pkg::*;
#(
    parameter int    DEPTH      = 64,
    parameter cell_t HEAD_RESET = INIT_HEAD,
    parameter cell_t TAIL_RESET = INIT_TAIL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_head,
    input  logic                     pop_tail,
    input  cell_t                    push_cell,
    output cell_t                    head,
    output cell_t                    tail,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    cell_t          mem [DEPTH];
    logic [AW-1:0]  hp;
    logic [AW-1:0]  tp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= HEAD_RESET;
            mem[0] <= TAIL_RESET;
            hp     <= AW'(1);
            tp     <= '0;
            count  <= (AW+1)'(2);
        end else begin
            if (push_head) begin
                mem[hp + 1'b1] <= push_cell;
                hp             <= hp + 1'b1;
            end
            if (pop_tail) tp <= tp + 1'b1;
            case ({push_head, pop_tail})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head = mem[hp];
    assign tail = mem[tp];

endmodule

// File: rtl/snake_logic.sv
// Snake game step engine: one board step per controller tick edge, food
// regeneration through a PRNG handshake, registered 8x8 LED image.
module snake_logic
    import snake_pkg::*;
#(
    parameter int    MAX_LEN    = 64,
    parameter cell_t HEAD_START = INIT_HEAD,
    parameter cell_t FOOD_START = INIT_FOOD
) (
    input  logic clka,
    input  logic restart,
    snake_if.slave bus
);

    localparam int          CW         = $clog2(MAX_LEN) + 1;
    localparam logic [CW-1:0] LAST     = CW'(MAX_LEN - 1);
    localparam cell_t       TAIL_START = step_cell(HEAD_START, DIR_LEFT);
    localparam logic [63:0] RESET_OCC  = (64'd1 << HEAD_START) | (64'd1 << TAIL_START);
    localparam logic [63:0] RESET_LED  = RESET_OCC | (64'd1 << FOOD_START);

    // Head is blanked after the OR so a full board never shows a stale food bit.
    function automatic logic [63:0] led_image(input logic [63:0] occ, input cell_t f,
                                              input cell_t h, input logic blink);
        return (occ | (64'd1 << f)) & ~(blink ? 64'd0 : (64'd1 << h));
    endfunction

    state_e        state;
    logic          tick_q;
    logic          blink_on;
    dir_e          dir_q;
    cell_t         nxt;
    logic          eat;
    logic          hit;
    cell_t         cand;
    cell_t         food;
    logic [63:0]   occupied;
    logic [63:0]   occ_next;
    logic [63:0]   led;
    logic [1:0]    from_logic;
    logic          req_r;

    cell_t         head;
    cell_t         tail;
    cell_t         step_c;
    logic [CW-1:0] count;
    logic          tick_edge;
    logic          push;
    logic          pop;

    assign tick_edge = bus.tick & ~tick_q;
    assign step_c    = step_cell(head, dir_q);
    assign push      = (state == S_COMMIT) && !hit;
    assign pop       = push && !eat;

    snake_body_fifo #(
        .DEPTH      (MAX_LEN),
        .HEAD_RESET (HEAD_START),
        .TAIL_RESET (TAIL_START)
    ) u_body (
        .clk       (clka),
        .rst       (restart),
        .push_head (push),
        .pop_tail  (pop),
        .push_cell (nxt),
        .head      (head),
        .tail      (tail),
        .count     (count)
    );

    // Set after clear so a head moving into the vacating tail cell stays lit.
    always_comb begin
        occ_next = occupied;
        if (pop) occ_next[tail] = 1'b0;
        occ_next[nxt] = 1'b1;
    end

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state      <= S_IDLE;
            tick_q     <= 1'b0;
            blink_on   <= 1'b1;
            dir_q      <= DIR_RIGHT;
            nxt        <= HEAD_START;
            eat        <= 1'b0;
            hit        <= 1'b0;
            cand       <= '0;
            food       <= FOOD_START;
            occupied   <= RESET_OCC;
            led        <= RESET_LED;
            from_logic <= 2'b00;
            req_r      <= 1'b0;
        end else begin
            tick_q <= bus.tick;
            unique case (state)
                S_IDLE: begin
                    if (tick_edge) begin
                        from_logic[LOGIC_DONE] <= 1'b0;
                        if (from_logic[GAME_END] || bus.no_update) begin
                            blink_on <= ~blink_on;
                            led      <= led_image(occupied, food, head, ~blink_on);
                            state    <= S_DONE;
                        end else begin
                            dir_q <= dir_e'(bus.direction);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    nxt   <= step_c;
                    eat   <= (step_c == food);
                    hit   <= occupied[step_c] && !((step_c == tail) && (step_c != food));
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (hit) begin
                        from_logic[GAME_END] <= 1'b1;
                        state                <= S_DONE;
                    end else begin
                        occupied <= occ_next;
                        led      <= led_image(occ_next, food, nxt, blink_on);
                        if (eat && (count == LAST)) begin
                            from_logic[GAME_END] <= 1'b1;
                            state                <= S_DONE;
                        end else if (eat) begin
                            req_r <= 1'b1;
                            state <= S_FOOD_REQ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_FOOD_REQ: begin
                    if (bus.rand_ack) begin
                        cand  <= bus.rand_val;
                        req_r <= 1'b0;
                        state <= S_FOOD_CHK;
                    end
                end
                S_FOOD_CHK: begin
                    if (occupied[cand]) begin
                        req_r <= 1'b1;
                        state <= S_FOOD_REQ;
                    end else begin
                        food  <= cand;
                        led   <= led_image(occupied, cand, head, blink_on);
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    from_logic[LOGIC_DONE] <= 1'b1;
                    state                  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.logic_done = from_logic[LOGIC_DONE];
    assign bus.game_end   = from_logic[GAME_END];
    assign bus.rand_req   = req_r;
    assign bus.led_flat   = led;

endmodule

// File: tb/tb_snake_logic.sv
// Directed bench for snake_logic: reset image, moves, eating with PRNG retry,
// wrap, self-collision, blink, tail-chasing and restart mid-handshake.
module tb_snake_logic;
    import snake_pkg::*;

    logic clka    = 1'b0;
    logic restart = 1'b0;

    snake_if bus();

    snake_logic dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    always #5 clka = ~clka;

    int          errors   = 0;
    int          checks   = 0;
    int          rounds   = 0;
    logic        req_seen = 1'b0;
    logic [5:0]  prng_q[$];

    // PRNG stand-in: one-cycle ack per request while values are queued.
    initial begin
        bus.rand_ack = 1'b0;
        bus.rand_val = '0;
        forever begin
            @(negedge clka);
            if (bus.rand_req === 1'b1 && !bus.rand_ack && prng_q.size() > 0) begin
                bus.rand_val = prng_q.pop_front();
                bus.rand_ack = 1'b1;
                rounds++;
            end else begin
                bus.rand_ack = 1'b0;
            end
        end
    end

    always @(posedge clka) if (bus.rand_req === 1'b1) req_seen = 1'b1;

    function automatic logic [63:0] oh(input int n);
        return 64'd1 << n;
    endfunction

    task automatic do_reset();
        bus.tick      = 1'b0;
        bus.no_update = 1'b0;
        bus.direction = 2'd0;
        prng_q.delete();
        @(negedge clka);
        restart = 1'b1;
        @(negedge clka);
        restart  = 1'b0;
        rounds   = 0;
        req_seen = 1'b0;
        @(negedge clka);
    endtask

    // One controller step; direction is scrambled right after the edge cycle.
    task automatic step(input logic [1:0] dir, input logic nu,
                        output int lat, output logic done0);
        @(negedge clka);
        bus.direction = dir;
        bus.no_update = nu;
        bus.tick      = 1'b1;
        @(posedge clka);
        @(negedge clka);
        bus.tick      = 1'b0;
        bus.no_update = 1'b0;
        bus.direction = ~dir;
        done0 = bus.logic_done;
        lat   = 0;
        while (bus.logic_done !== 1'b1 && lat < 60) begin
            @(negedge clka);
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [63:0] img;
        img = oh('o33) | oh('o32) | oh('o36);
        bus.tick = 1'b0; bus.no_update = 1'b0; bus.direction = 2'd0;
        @(negedge clka);
        restart = 1'b1;
        #1;
        checks++; if (bus.logic_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.logic_done); end
        checks++; if (bus.game_end !== 1'b0) begin errors++; $display("FAIL reset_end got=%b want=0", bus.game_end); end
        checks++; if (bus.rand_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.rand_req); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL reset_led got=%h want=%h", bus.led_flat, img); end
        @(negedge clka);
        restart  = 1'b0;
        req_seen = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_move_right();
        int lat; logic d0; logic [63:0] img;
        img = oh('o34) | oh('o33) | oh('o36);
        step(2'd3, 1'b0, lat, d0);
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL move_done_early got=%b want=0", d0); end
        checks++; if (lat != 3) begin errors++; $display("FAIL move_latency got=%0d want=3", lat); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL move_led got=%h want=%h", bus.led_flat, img); end
        checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL move_no_req got=%b want=0", req_seen); end
    endtask

    task automatic test_eat_retry();
        int lat; logic d0; logic [63:0] img;
        img = oh('o36) | oh('o35) | oh('o34) | oh('o00);
        step(2'd3, 1'b0, lat, d0);
        rounds = 0;
        prng_q.push_back(6'o35);
        prng_q.push_back(6'o00);
        step(2'd3, 1'b0, lat, d0);
        checks++; if (lat != 7) begin errors++; $display("FAIL eat_latency got=%0d want=7", lat); end
        checks++; if (rounds != 2) begin errors++; $display("FAIL eat_rounds got=%0d want=2", rounds); end
        checks++; if (req_seen !== 1'b1) begin errors++; $display("FAIL eat_req got=%b want=1", req_seen); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL eat_led got=%h want=%h", bus.led_flat, img); end
    endtask

    task automatic test_wrap();
        int lat; logic d0; logic [63:0] img;
        img = oh('o30) | oh('o37) | oh('o36) | oh('o00);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL wrap_led got=%h want=%h", bus.led_flat, img); end
        checks++; if (bus.game_end !== 1'b0) begin errors++; $display("FAIL wrap_end got=%b want=0", bus.game_end); end
    endtask

    task automatic test_collision_blink();
        int lat; logic d0; logic [63:0] img;
        img = oh('o46) | oh('o47) | oh('o37) | oh('o36) | oh('o35) | oh('o00);
        do_reset();
        prng_q.push_back(6'o37);
        prng_q.push_back(6'o47);
        prng_q.push_back(6'o00);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        step(2'd0, 1'b0, lat, d0);
        step(2'd2, 1'b0, lat, d0);
        step(2'd1, 1'b0, lat, d0);
        checks++; if (lat != 3) begin errors++; $display("FAIL hit_latency got=%0d want=3", lat); end
        checks++; if (bus.game_end !== 1'b1) begin errors++; $display("FAIL hit_end got=%b want=1", bus.game_end); end
        checks++; if (bus.logic_done !== 1'b1) begin errors++; $display("FAIL hit_done got=%b want=1", bus.logic_done); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL hit_led got=%h want=%h", bus.led_flat, img); end
        step(2'd3, 1'b1, lat, d0);
        checks++; if (lat != 1) begin errors++; $display("FAIL blink_latency got=%0d want=1", lat); end
        checks++; if (bus.led_flat !== (img & ~oh('o46))) begin errors++; $display("FAIL blink_off got=%h want=%h", bus.led_flat, img & ~oh('o46)); end
        step(2'd3, 1'b1, lat, d0);
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL blink_on got=%h want=%h", bus.led_flat, img); end
    endtask

    task automatic test_tail_chase();
        int lat; logic d0; logic [63:0] img;
        img = oh('o36) | oh('o46) | oh('o47) | oh('o37) | oh('o00);
        do_reset();
        prng_q.push_back(6'o37);
        prng_q.push_back(6'o00);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        step(2'd0, 1'b0, lat, d0);
        step(2'd2, 1'b0, lat, d0);
        step(2'd1, 1'b0, lat, d0);
        checks++; if (bus.game_end !== 1'b0) begin errors++; $display("FAIL chase_end got=%b want=0", bus.game_end); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL chase_led got=%h want=%h", bus.led_flat, img); end
        step(2'd3, 1'b0, lat, d0);
        checks++; if (bus.game_end !== 1'b0) begin errors++; $display("FAIL chase2_end got=%b want=0", bus.game_end); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL chase2_led got=%h want=%h", bus.led_flat, img); end
    endtask

    task automatic test_restart_mid_handshake();
        int lat; int waited; logic d0; logic [63:0] img;
        img = oh('o33) | oh('o32) | oh('o36);
        do_reset();
        step(2'd3, 1'b0, lat, d0);
        step(2'd3, 1'b0, lat, d0);
        @(negedge clka);
        bus.direction = 2'd3;
        bus.tick      = 1'b1;
        waited = 0;
        while (bus.rand_req !== 1'b1 && waited < 20) begin
            @(negedge clka);
            bus.tick = 1'b0;
            waited++;
        end
        bus.tick = 1'b0;
        checks++; if (bus.rand_req !== 1'b1) begin errors++; $display("FAIL restart_req_wait got=%b want=1", bus.rand_req); end
        #1 restart = 1'b1;
        #1;
        checks++; if (bus.rand_req !== 1'b0) begin errors++; $display("FAIL restart_req got=%b want=0", bus.rand_req); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL restart_led got=%h want=%h", bus.led_flat, img); end
        checks++; if (bus.game_end !== 1'b0) begin errors++; $display("FAIL restart_end got=%b want=0", bus.game_end); end
        @(negedge clka);
        @(negedge clka);
        restart = 1'b0;
        @(negedge clka);
        img = oh('o34) | oh('o33) | oh('o36);
        step(2'd3, 1'b0, lat, d0);
        checks++; if (lat != 3) begin errors++; $display("FAIL restart_step_latency got=%0d want=3", lat); end
        checks++; if (bus.led_flat !== img) begin errors++; $display("FAIL restart_step_led got=%h want=%h", bus.led_flat, img); end
    endtask

    initial begin
        bus.tick      = 1'b0;
        bus.no_update = 1'b0;
        bus.direction = 2'd0;
        test_reset();
        test_move_right();
        test_eat_retry();
        test_wrap();
        test_collision_blink();
        test_tail_chase();
        test_restart_mid_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
